// File: rtl/branch_pc_ctrl.sv
// -----------------------------------------------------------------------------
// branch_pc_ctrl
//
// Owns the program counter and the architectural carry flag, and resolves
// long branches against the registered carry. A taken branch redirects the
// PC, raises a one-cycle flush towards fetch/decode and, for branch-and-link,
// emits a one-cycle link-register write carrying the return address. A halt
// instruction freezes the PC and carry until reset.
//
// Ports:
//   clk         system clock, all state changes on the rising edge
//   rst_n       asynchronous active-low reset
//   pc_en       advance enable (0 = stall; carry still updates)
//   carry_in    ALU carry-out
//   carry_we    latch carry_in into carry_q
//   LongBr      current instruction is a long branch
//   LongBrType  00 uncond, 01 branch-and-link, 10 if carry, 11 if no carry
//   br_target   branch destination (bits [1:0] forced to 0)
//   halt_in     current instruction is halt
//   pc          current fetch address
//   carry_q     architectural carry flag
//   flush       squash the instruction in fetch/decode
//   link_we     one-cycle link register write strobe
//   link_data   return address, valid with link_we
//   halted      core halted
// -----------------------------------------------------------------------------
module branch_pc_ctrl #(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_en,
  input  logic              carry_in,
  input  logic              carry_we,
  input  logic              LongBr,
  input  logic [1:0]        LongBrType,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              halt_in,
  output logic [ADDR_W-1:0] pc,
  output logic              carry_q,
  output logic              flush,
  output logic              link_we,
  output logic [ADDR_W-1:0] link_data,
  output logic              halted
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } stateT;

  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(3));

  stateT             stateReg, stateNext;
  logic [ADDR_W-1:0] pcReg, pcNext;
  logic [ADDR_W-1:0] linkDataReg, linkDataNext;
  logic              carryReg, carryNext;
  logic              flushReg, flushNext;
  logic              linkWeReg, linkWeNext;
  logic              haltedReg, haltedNext;

  logic [3:0]        condVec;
  logic              taken;
  logic [ADDR_W-1:0] pcPlus;
  logic [ADDR_W-1:0] targetAligned;

  // Branch condition per LongBrType encoding. Only the registered carry is
  // consulted, so a carry write in the same cycle never affects the branch.
  for (genvar gi = 0; gi < 4; gi++) begin : gCond
    if (gi < 2) begin : gAlways
      assign condVec[gi] = 1'b1;
    end else if (gi == 2) begin : gCarry
      assign condVec[gi] = carryReg;
    end else begin : gNoCarry
      assign condVec[gi] = ~carryReg;
    end
  end

  assign taken         = LongBr & condVec[LongBrType];
  assign pcPlus        = pcReg + STEP;  // wraps modulo 2^ADDR_W
  assign targetAligned = br_target & ALIGN_MASK;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= RUN;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Next-state logic
  always_comb begin
    stateNext = stateReg;
    unique case (stateReg)
      RUN: begin
        if (pc_en) begin
          if (halt_in) begin
            stateNext = HALT;
          end else if (taken) begin
            stateNext = FLUSH;
          end
        end
      end
      FLUSH:   stateNext = RUN;  // exactly one cycle, pc_en does not matter
      HALT:    stateNext = HALT; // only reset leaves HALT
      default: stateNext = RUN;
    endcase
  end

  // Output / datapath next values (all outputs are registered below)
  always_comb begin
    pcNext       = pcReg;
    linkDataNext = linkDataReg;
    flushNext    = 1'b0;
    linkWeNext   = 1'b0;
    haltedNext   = (stateReg == HALT);
    carryNext    = (carry_we && stateReg != HALT) ? carry_in : carryReg;

    if (stateReg == RUN && pc_en) begin
      if (halt_in) begin
        haltedNext = 1'b1;
      end else if (taken) begin
        pcNext    = targetAligned;
        flushNext = 1'b1;
        if (LongBrType == 2'b01) begin
          linkWeNext   = 1'b1;
          linkDataNext = pcPlus;
        end
      end else begin
        pcNext = pcPlus;
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcReg       <= RESET_PC;
      linkDataReg <= '0;
      carryReg    <= 1'b0;
      flushReg    <= 1'b0;
      linkWeReg   <= 1'b0;
      haltedReg   <= 1'b0;
    end else begin
      pcReg       <= pcNext;
      linkDataReg <= linkDataNext;
      carryReg    <= carryNext;
      flushReg    <= flushNext;
      linkWeReg   <= linkWeNext;
      haltedReg   <= haltedNext;
    end
  end

  assign pc        = pcReg;
  assign carry_q   = carryReg;
  assign flush     = flushReg;
  assign link_we   = linkWeReg;
  assign link_data = linkDataReg;
  assign halted    = haltedReg;

endmodule

// File: tb/tb_branch_pc_ctrl.sv
module tb_branch_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_en;
  logic        carry_in;
  logic        carry_we;
  logic        LongBr;
  logic [1:0]  LongBrType;
  logic [31:0] br_target;
  logic        halt_in;
  logic [31:0] pc;
  logic        carry_q;
  logic        flush;
  logic        link_we;
  logic [31:0] link_data;
  logic        halted;

  int compared   = 0;
  int mismatched = 0;

  branch_pc_ctrl #(.ADDR_W(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_en      (pc_en),
    .carry_in   (carry_in),
    .carry_we   (carry_we),
    .LongBr     (LongBr),
    .LongBrType (LongBrType),
    .br_target  (br_target),
    .halt_in    (halt_in),
    .pc         (pc),
    .carry_q    (carry_q),
    .flush      (flush),
    .link_we    (link_we),
    .link_data  (link_data),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs, let one rising edge pass, settle away from it.
  task automatic drive(input logic en, input logic cwe, input logic cin,
                       input logic br, input logic [1:0] typ,
                       input logic [31:0] tgt, input logic hlt);
    pc_en      = en;
    carry_we   = cwe;
    carry_in   = cin;
    LongBr     = br;
    LongBrType = typ;
    br_target  = tgt;
    halt_in    = hlt;
    @(posedge clk);
    #1;
    $display("step t=%0t pc=0x%08h carry=%0b flush=%0b link_we=%0b link=0x%08h halted=%0b",
             $time, pc, carry_q, flush, link_we, link_data, halted);
  endtask

  initial begin
    rst_n = 1'b0;
    pc_en = 1'b0; carry_we = 1'b0; carry_in = 1'b0;
    LongBr = 1'b0; LongBrType = 2'b00; br_target = '0; halt_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_carry", {31'b0, carry_q}, 32'h0);
    chk("rst_flush", {31'b0, flush}, 32'h0);
    chk("rst_link_we", {31'b0, link_we}, 32'h0);
    chk("rst_link_data", link_data, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    rst_n = 1'b1;

    // Sequential run, setting carry on the way
    drive(1, 1, 1, 0, 2'b00, 32'h0, 0);
    chk("seq_pc4", pc, 32'h4);
    chk("seq_carry_set", {31'b0, carry_q}, 32'h1);
    drive(1, 0, 0, 0, 2'b00, 32'h0, 0);
    chk("seq_pc8", pc, 32'h8);

    // Async reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pc", pc, 32'h0);
    chk("async_rst_carry", {31'b0, carry_q}, 32'h0);
    rst_n = 1'b1;

    // Carry-conditional matrix with carry_q = 1
    drive(1, 1, 1, 0, 2'b00, 32'h0, 0);
    chk("c1_pc", pc, 32'h4);
    drive(1, 0, 0, 1, 2'b10, 32'h100, 0);
    chk("bc_c1_pc", pc, 32'h100);
    chk("bc_c1_flush", {31'b0, flush}, 32'h1);
    drive(1, 0, 0, 0, 2'b00, 32'h0, 0);
    chk("bc_c1_flushcyc_pc", pc, 32'h100);
    chk("bc_c1_flushcyc_flush", {31'b0, flush}, 32'h0);
    drive(1, 0, 0, 1, 2'b11, 32'h100, 0);
    chk("bnc_c1_pc", pc, 32'h104);
    chk("bnc_c1_flush", {31'b0, flush}, 32'h0);

    // Same matrix with carry_q = 0
    drive(1, 1, 0, 0, 2'b00, 32'h0, 0);
    chk("c0_pc", pc, 32'h108);
    chk("c0_carry", {31'b0, carry_q}, 32'h0);
    drive(1, 0, 0, 1, 2'b10, 32'h300, 0);
    chk("bc_c0_pc", pc, 32'h10C);
    chk("bc_c0_flush", {31'b0, flush}, 32'h0);
    drive(1, 0, 0, 1, 2'b11, 32'h300, 0);
    chk("bnc_c0_pc", pc, 32'h300);
    chk("bnc_c0_flush", {31'b0, flush}, 32'h1);
    drive(1, 0, 0, 0, 2'b00, 32'h0, 0);
    chk("bnc_c0_flushcyc_pc", pc, 32'h300);

    // LongBr=0 never branches
    drive(1, 0, 0, 0, 2'b00, 32'h500, 0);
    chk("nobr_t00_pc", pc, 32'h304);
    drive(1, 0, 0, 0, 2'b01, 32'h500, 0);
    chk("nobr_t01_pc", pc, 32'h308);
    chk("nobr_t01_link_we", {31'b0, link_we}, 32'h0);

    // Same-cycle carry write does not affect the branch
    drive(1, 1, 1, 1, 2'b10, 32'h400, 0);
    chk("samecyc_pc", pc, 32'h30C);
    chk("samecyc_flush", {31'b0, flush}, 32'h0);
    chk("samecyc_carry", {31'b0, carry_q}, 32'h1);

    // Branch-and-link from 0x20
    drive(1, 0, 0, 1, 2'b00, 32'h20, 0);
    chk("uncond_pc", pc, 32'h20);
    chk("uncond_link_we", {31'b0, link_we}, 32'h0);
    drive(1, 0, 0, 0, 2'b00, 32'h0, 0);
    drive(1, 0, 0, 1, 2'b01, 32'h203, 0);
    chk("bl_pc", pc, 32'h200);
    chk("bl_link_we", {31'b0, link_we}, 32'h1);
    chk("bl_link_data", link_data, 32'h24);
    chk("bl_flush", {31'b0, flush}, 32'h1);
    drive(1, 0, 0, 1, 2'b01, 32'h203, 0);
    chk("bl_flushcyc_pc", pc, 32'h200);
    chk("bl_flushcyc_link_we", {31'b0, link_we}, 32'h0);
    chk("bl_flushcyc_flush", {31'b0, flush}, 32'h0);
    chk("bl_flushcyc_link_data", link_data, 32'h24);
    drive(1, 0, 0, 0, 2'b00, 32'h0, 0);
    chk("bl_after_pc", pc, 32'h204);

    // Stall
    drive(0, 0, 0, 1, 2'b00, 32'h600, 0);
    chk("stall_pc", pc, 32'h204);
    chk("stall_flush", {31'b0, flush}, 32'h0);

    // Halt wins over a taken branch; carry frozen while halted
    drive(1, 0, 0, 1, 2'b00, 32'h600, 1);
    chk("halt_halted", {31'b0, halted}, 32'h1);
    chk("halt_pc", pc, 32'h204);
    chk("halt_flush", {31'b0, flush}, 32'h0);
    drive(1, 1, 0, 1, 2'b00, 32'h600, 0);
    chk("halt_hold_pc", pc, 32'h204);
    chk("halt_hold_carry", {31'b0, carry_q}, 32'h1);
    chk("halt_hold_halted", {31'b0, halted}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("halt_rst_halted", {31'b0, halted}, 32'h0);
    chk("halt_rst_pc", pc, 32'h0);
    rst_n = 1'b1;

    // Reset during FLUSH drops the pending link write
    drive(1, 0, 0, 1, 2'b01, 32'h40, 0);
    chk("bl2_link_data", link_data, 32'h4);
    chk("bl2_link_we", {31'b0, link_we}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("flush_rst_link_we", {31'b0, link_we}, 32'h0);
    chk("flush_rst_link_data", link_data, 32'h0);
    chk("flush_rst_flush", {31'b0, flush}, 32'h0);
    chk("flush_rst_pc", pc, 32'h0);
    rst_n = 1'b1;

    // Wrap at the top of the address space
    drive(1, 0, 0, 1, 2'b00, 32'hFFFF_FFFF, 0);
    chk("wrap_target_pc", pc, 32'hFFFF_FFFC);
    drive(1, 0, 0, 0, 2'b00, 32'h0, 0);
    drive(1, 0, 0, 0, 2'b00, 32'h0, 0);
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_flush", {31'b0, flush}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/branch_pc_ctrl.md
Name: branch_pc_ctrl

Overview:
- Producer and consumer side of the long-branch decision path. Holds the architectural carry flag and the program counter.
- Resolves LongBr/LongBrType against the registered carry and steers the next PC. Generates the link write for branch-and-link and a one-cycle pipeline flush after every taken branch.
- Sits between the decode stage (supplies LongBr, LongBrType, target), the ALU (supplies carry), and instruction fetch (consumes pc, flush).

Parameters:
- ADDR_W, 32, width of PC, target and link data.
- RESET_PC, 0, PC value loaded on reset; low 2 bits must be 0.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pc_en  input  1  advance enable; 0 = stall, all state held except carry.
- carry_in  input  1  ALU carry-out.
- carry_we  input  1  latch carry_in into carry_q.
- LongBr  input  1  current instruction is a long branch.
- LongBrType  input  2  00 unconditional, 01 branch-and-link, 10 branch if carry, 11 branch if no carry.
- br_target  input  ADDR_W  branch destination; bits [1:0] ignored and forced to 0.
- halt_in  input  1  current instruction is halt.
- pc  output  ADDR_W  current fetch address (registered).
- carry_q  output  1  architectural carry flag (registered).
- flush  output  1  squash the instruction in fetch/decode (registered).
- link_we  output  1  one-cycle write strobe for the link register (registered).
- link_data  output  ADDR_W  return address, valid when link_we=1 (registered).
- halted  output  1  core halted (registered).

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, carry_q=0, flush=0, link_we=0, link_data=0, halted=0, state=RUN. Deassertion is sampled synchronously; first update on the first rising edge with rst_n=1.
- Decision, combinational internally: taken = LongBr & (T==00 | T==01 | (T==10 & carry_q) | (T==11 & ~carry_q)).
  - Uses registered carry_q only. No bypass: a carry_we in the same cycle as a conditional branch does not affect that branch.
- Carry: carry_q <= carry_in when carry_we=1 and state!=HALT. This is independent of pc_en.
- FSM states: RUN, FLUSH, HALT.
- RUN, pc_en=0: pc, state and link_data hold. flush=0, link_we=0.
- RUN, pc_en=1, priority halt_in > taken > sequential:
  - halt_in=1: pc holds, state->HALT, halted=1 next cycle. LongBr is ignored.
  - taken: pc <= {br_target[ADDR_W-1:2],2'b00}; flush=1 next cycle; state->FLUSH.
    - If T==01, additionally link_we=1 and link_data=pc+PC_STEP next cycle.
  - otherwise: pc <= pc+PC_STEP, modulo 2^ADDR_W (wraps to 0 at the top, no flag).
  - A not-taken conditional branch behaves exactly like sequential.
- FLUSH: lasts exactly one cycle regardless of pc_en. flush=0 and link_we=0 on exit. All branch/halt inputs in this cycle are ignored. pc holds the target. Next state is RUN.
- HALT: pc, link_data and carry_q frozen. flush=0, link_we=0, halted=1. Only rst_n exits HALT.
- link_we is a single-cycle pulse and never asserts outside the cycle following a taken T==01.
- Reset mid-FLUSH or mid-HALT returns immediately to the reset values; any pending link write is dropped.
- LongBr=0 never changes pc except by PC_STEP, whatever LongBrType and carry are.

Test Plan:
- Reset: rst_n=0 async mid-cycle -> pc=0, carry_q=0, flush=0, halted=0 immediately. Release with pc_en=1, no branch -> pc 0,4,8 on successive edges.
- Carry-conditional matrix: carry_we=1, carry_in=1, then LongBr=1, T=10, target=0x100 -> pc=0x100 and flush=1 for one cycle. Repeat with T=11 -> pc=prev+4, flush=0. Repeat both with carry_q=0 -> results inverted. All four with LongBr=0 -> always pc+4.
- Branch-and-link: pc=0x20, LongBr=1, T=01, target=0x203 -> pc=0x200, link_we=1, link_data=0x24 for exactly one cycle. Branch inputs held during FLUSH are ignored; pc=0x204 the cycle after.
- Same-cycle carry write: carry_q=0, carry_we=1, carry_in=1, LongBr=1, T=10 -> not taken (pc+4); carry_q=1 afterwards.
- Stall and halt: pc_en=0 with LongBr=1, T=00 -> pc unchanged, flush=0. halt_in=1 together with LongBr=1, T=00 and pc_en=1 -> halted=1, pc frozen, further carry_we ignored until rst_n.
- Wrap: pc=0xFFFFFFFC, sequential step -> pc=0x00000000, no flush.
